// File: rtl/trx_link_sup.sv
// trx_link_sup - bring-up / recovery supervisor for one 10GBASE-R transceiver lane.
//
// The supervisor drives the transceiver reset controller and waits for TX ready,
// RX ready and PCS block lock, in that order. Each wait phase has a timeout. A
// failed attempt re-issues a timed reset. After MAX_RETRY failed attempts the
// supervisor parks in FAULT (MAX_RETRY = 0 retries forever).
//
// Optional feature macro: TRX_LINK_SUP_STATS_EN adds the drop_cnt port and its counter.
//
// Ports:
//   clk_glbl   in   single clock
//   rst_glbl   in   synchronous reset, active high
//   en         in   supervisor enable (level)
//   pma_tx_rdy in   TX ready from the reset controller (asynchronous)
//   pma_rx_rdy in   RX ready from the reset controller (asynchronous)
//   block_lock in   PCS block lock from the RX clock domain (asynchronous)
//   trx_rst    out  reset to the transceiver reset controller
//   link_up    out  link usable; gates the MAC
//   state      out  current state encoding
//   retry_cnt  out  failed attempts since the last enable, saturating
//   fault      out  retries exhausted
//   drop_cnt   out  lock drops while UP, saturating (TRX_LINK_SUP_STATS_EN only)
module trx_link_sup #(
    parameter int unsigned RST_HOLD_CYC    = 256,
    parameter int unsigned TX_TMO_CYC      = 1000000,
    parameter int unsigned RX_TMO_CYC      = 1000000,
    parameter int unsigned LOCK_TMO_CYC    = 2000000,
    parameter int unsigned UP_DEBOUNCE_CYC = 1024,
    parameter int unsigned MAX_RETRY       = 8,
    parameter int unsigned CNT_W           = 24
) (
    input  logic        clk_glbl,
    input  logic        rst_glbl,
    input  logic        en,
    input  logic        pma_tx_rdy,
    input  logic        pma_rx_rdy,
    input  logic        block_lock,
    output logic        trx_rst,
    output logic        link_up,
    output logic [2:0]  state,
    output logic [7:0]  retry_cnt,
    output logic        fault
`ifdef TRX_LINK_SUP_STATS_EN
    ,
    output logic [15:0] drop_cnt
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_HOLD      = 3'd1,
        ST_WAIT_TX   = 3'd2,
        ST_WAIT_RX   = 3'd3,
        ST_WAIT_LOCK = 3'd4,
        ST_DEBOUNCE  = 3'd5,
        ST_UP        = 3'd6,
        ST_FAULT     = 3'd7
    } state_e;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] TX_LAST   = CNT_W'(TX_TMO_CYC - 1);
    localparam logic [CNT_W-1:0] RX_LAST   = CNT_W'(RX_TMO_CYC - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TMO_CYC - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(UP_DEBOUNCE_CYC - 1);

    logic [1:0]       tx_sync_q, rx_sync_q, lk_sync_q;
    logic             tx_s, rx_s, lk_s;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [7:0]       retry_q, retry_d;
    logic [7:0]       retry_inc;
    logic             retry_evt;
    logic             ready_ok;
`ifdef TRX_LINK_SUP_STATS_EN
    logic [15:0]      drop_q;
    logic             drop_evt;
`endif

    // Two-flop synchronizers; the FSM only ever looks at the second stage.
    always_ff @(posedge clk_glbl) begin
        if (rst_glbl) begin
            tx_sync_q <= '0;
            rx_sync_q <= '0;
            lk_sync_q <= '0;
        end else begin
            tx_sync_q <= {tx_sync_q[0], pma_tx_rdy};
            rx_sync_q <= {rx_sync_q[0], pma_rx_rdy};
            lk_sync_q <= {lk_sync_q[0], block_lock};
        end
    end

    assign tx_s     = tx_sync_q[1];
    assign rx_s     = rx_sync_q[1];
    assign lk_s     = lk_sync_q[1];
    assign ready_ok = tx_s && rx_s;

    assign retry_inc = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;

    // Next state. A single retry_evt flag per cycle means a simultaneous loss of
    // ready and timeout is counted only once.
    always_comb begin
        state_d   = state_q;
        retry_evt = 1'b0;
        retry_d   = retry_q;
`ifdef TRX_LINK_SUP_STATS_EN
        drop_evt  = 1'b0;
`endif
        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_HOLD;
                    retry_d = '0;
                end
                ST_HOLD: begin
                    if (timer_q == HOLD_LAST) state_d = ST_WAIT_TX;
                end
                ST_WAIT_TX: begin
                    if (timer_q == TX_LAST) retry_evt = 1'b1;
                    else if (tx_s)          state_d = ST_WAIT_RX;
                end
                ST_WAIT_RX: begin
                    if (!tx_s || timer_q == RX_LAST) retry_evt = 1'b1;
                    else if (rx_s)                   state_d = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (!ready_ok || timer_q == LOCK_LAST) retry_evt = 1'b1;
                    else if (lk_s)                         state_d = ST_DEBOUNCE;
                end
                ST_DEBOUNCE: begin
                    if (!ready_ok)                retry_evt = 1'b1;
                    else if (!lk_s)               state_d = ST_WAIT_LOCK;
                    else if (timer_q == DEB_LAST) state_d = ST_UP;
                end
                ST_UP: begin
                    if (!ready_ok) begin
                        retry_evt = 1'b1;
                    end else if (!lk_s) begin
                        state_d = ST_WAIT_LOCK;
`ifdef TRX_LINK_SUP_STATS_EN
                        drop_evt = 1'b1;
`endif
                    end
                end
                ST_FAULT: state_d = ST_FAULT;
                default:  state_d = ST_IDLE;
            endcase

            if (retry_evt) begin
                retry_d = retry_inc;
                if (MAX_RETRY != 0 && 32'(retry_inc) >= MAX_RETRY) state_d = ST_FAULT;
                else                                              state_d = ST_HOLD;
            end
        end
    end

    // Phase timer restarts on any state change, otherwise counts and saturates.
    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q)   timer_d = '0;
        else if (timer_q != '1)   timer_d = timer_q + CNT_W'(1);
    end

    always_ff @(posedge clk_glbl) begin
        if (rst_glbl) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            retry_q <= retry_d;
        end
    end

`ifdef TRX_LINK_SUP_STATS_EN
    always_ff @(posedge clk_glbl) begin
        if (rst_glbl)                        drop_q <= '0;
        else if (drop_evt && drop_q != '1)   drop_q <= drop_q + 16'd1;
    end

    assign drop_cnt = drop_q;
`endif

    assign trx_rst   = (state_q == ST_IDLE) || (state_q == ST_HOLD) || (state_q == ST_FAULT);
    assign link_up   = (state_q == ST_UP);
    assign fault     = (state_q == ST_FAULT);
    assign state     = state_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_trx_link_sup.sv
// tb_trx_link_sup - directed self-checking bench for trx_link_sup.
// Uses RST_HOLD_CYC=8, all timeouts 64, UP_DEBOUNCE_CYC=16, MAX_RETRY=3.
// Inputs change 1 time unit after a rising edge, and outputs are sampled at
// that same point. An input driven after edge E0 therefore moves the state at E3.
module tb_trx_link_sup;

    logic        clk_glbl = 1'b0;
    logic        rst_glbl;
    logic        en;
    logic        pma_tx_rdy;
    logic        pma_rx_rdy;
    logic        block_lock;
    logic        trx_rst;
    logic        link_up;
    logic [2:0]  state;
    logic [7:0]  retry_cnt;
    logic        fault;
`ifdef TRX_LINK_SUP_STATS_EN
    logic [15:0] drop_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    trx_link_sup #(
        .RST_HOLD_CYC    (8),
        .TX_TMO_CYC      (64),
        .RX_TMO_CYC      (64),
        .LOCK_TMO_CYC    (64),
        .UP_DEBOUNCE_CYC (16),
        .MAX_RETRY       (3),
        .CNT_W           (24)
    ) dut (
        .clk_glbl   (clk_glbl),
        .rst_glbl   (rst_glbl),
        .en         (en),
        .pma_tx_rdy (pma_tx_rdy),
        .pma_rx_rdy (pma_rx_rdy),
        .block_lock (block_lock),
        .trx_rst    (trx_rst),
        .link_up    (link_up),
        .state      (state),
        .retry_cnt  (retry_cnt),
        .fault      (fault)
`ifdef TRX_LINK_SUP_STATS_EN
        ,
        .drop_cnt   (drop_cnt)
`endif
    );

    always #5 clk_glbl = ~clk_glbl;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_glbl);
        #1;
    endtask

    initial begin
        int rcnt, fall, rise, st3, st15, st23, n_hold, n_wtx, flt_at;

        rst_glbl = 1'b1; en = 1'b0;
        pma_tx_rdy = 1'b0; pma_rx_rdy = 1'b0; block_lock = 1'b0;
        repeat (3) step();
        check_eq("rst_state",   state,     0);
        check_eq("rst_trx_rst", trx_rst,   1);
        check_eq("rst_link_up", link_up,   0);
        check_eq("rst_fault",   fault,     0);
        check_eq("rst_retry",   retry_cnt, 0);
`ifdef TRX_LINK_SUP_STATS_EN
        check_eq("rst_drop",    drop_cnt,  0);
`endif
        rst_glbl = 1'b0;
        step();
        check_eq("idle_no_en", state, 0);

        // Bring-up: en at cycle 0, tx at 20, rx at 30, lock at 40 -> UP at 59.
        en = 1'b1; rcnt = 0; rise = -1;
        for (int c = 1; c <= 70; c++) begin
            step();
            if (trx_rst) rcnt++;
            if (link_up && rise < 0) rise = c;
            if (c == 20) pma_tx_rdy = 1'b1;
            if (c == 30) pma_rx_rdy = 1'b1;
            if (c == 40) block_lock = 1'b1;
        end
        check_eq("bu_rst_len", rcnt,      8);
        check_eq("bu_up_at",   rise,      59);
        check_eq("bu_retry",   retry_cnt, 0);
        check_eq("bu_state",   state,     6);

        // Lock drop in UP for 5 cycles: WAIT_LOCK at 3, DEBOUNCE at 8, UP at 24.
        block_lock = 1'b0; rcnt = 0; fall = -1; rise = -1; st3 = -1;
        for (int c = 1; c <= 30; c++) begin
            step();
            if (trx_rst) rcnt++;
            if (!link_up && fall < 0) fall = c;
            if (link_up && fall >= 0 && rise < 0) rise = c;
            if (c == 3) st3 = state;
            if (c == 5) block_lock = 1'b1;
        end
        check_eq("drop_fall",  fall, 3);
        check_eq("drop_state", st3,  4);
        check_eq("drop_norst", rcnt, 0);
        check_eq("drop_up_at", rise, 24);
`ifdef TRX_LINK_SUP_STATS_EN
        check_eq("drop_cnt1",  drop_cnt, 1);
`endif

        // Glitch in DEBOUNCE: lock back at 10 (DEBOUNCE at 13), low at 20..21,
        // WAIT_LOCK at 23, DEBOUNCE again at 25, UP at 41.
        block_lock = 1'b0; rcnt = 0; fall = -1; rise = -1; st15 = -1; st23 = -1;
        for (int c = 1; c <= 50; c++) begin
            step();
            if (trx_rst) rcnt++;
            if (!link_up && fall < 0) fall = c;
            if (link_up && fall >= 0 && rise < 0) rise = c;
            if (c == 15) st15 = state;
            if (c == 23) st23 = state;
            if (c == 10) block_lock = 1'b1;
            if (c == 20) block_lock = 1'b0;
            if (c == 22) block_lock = 1'b1;
        end
        check_eq("gl_fall",   fall,  3);
        check_eq("gl_deb",    st15,  5);
        check_eq("gl_back",   st23,  4);
        check_eq("gl_up_at",  rise,  41);
        check_eq("gl_norst",  rcnt,  0);
`ifdef TRX_LINK_SUP_STATS_EN
        check_eq("gl_drop2",  drop_cnt, 2);
`endif

        // RX ready lost in UP: HOLD at 3 for 8 cycles, rx back at 5, UP at 30.
        pma_rx_rdy = 1'b0; rcnt = 0; fall = -1; rise = -1; st3 = -1;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (trx_rst) rcnt++;
            if (!link_up && fall < 0) fall = c;
            if (link_up && fall >= 0 && rise < 0) rise = c;
            if (c == 3) st3 = state;
            if (c == 5) pma_rx_rdy = 1'b1;
        end
        check_eq("rx_state", st3,       1);
        check_eq("rx_rstlen", rcnt,     8);
        check_eq("rx_retry", retry_cnt, 1);
        check_eq("rx_up_at", rise,      30);

        // en off in UP: IDLE on the next edge, retry_cnt holds.
        en = 1'b0;
        step();
        check_eq("off_state",   state,     0);
        check_eq("off_trx_rst", trx_rst,   1);
        check_eq("off_link_up", link_up,   0);
        check_eq("off_retry",   retry_cnt, 1);

        // en off during WAIT_RX: WAIT_TX at 9, tx at 9 -> WAIT_RX at 12.
        pma_tx_rdy = 1'b0; pma_rx_rdy = 1'b0; block_lock = 1'b0;
        repeat (3) step();
        en = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (c == 1) begin
                check_eq("en_hold",     state,     1);
                check_eq("en_retry_cl", retry_cnt, 0);
            end
            if (c == 9) pma_tx_rdy = 1'b1;
        end
        check_eq("wrx_state", state, 3);
        en = 1'b0;
        step();
        check_eq("wrx_off_state", state,     0);
        check_eq("wrx_off_rst",   trx_rst,   1);
        check_eq("wrx_off_retry", retry_cnt, 0);
        check_eq("wrx_off_fault", fault,     0);

        // TX never ready: 3 x 64 WAIT_TX, 3 x 8 HOLD, FAULT at 217.
        pma_tx_rdy = 1'b0;
        repeat (3) step();
        en = 1'b1; rcnt = 0; n_hold = 0; n_wtx = 0; flt_at = -1;
        for (int c = 1; c <= 230; c++) begin
            step();
            if (trx_rst) rcnt++;
            if (state == 3'd1) n_hold++;
            if (state == 3'd2) n_wtx++;
            if (fault && flt_at < 0) flt_at = c;
        end
        check_eq("flt_hold",   n_hold,    24);
        check_eq("flt_wtx",    n_wtx,     192);
        check_eq("flt_at",     flt_at,    217);
        check_eq("flt_rstcyc", rcnt,      38);
        check_eq("flt_fault",  fault,     1);
        check_eq("flt_retry",  retry_cnt, 3);
        check_eq("flt_trxrst", trx_rst,   1);
        check_eq("flt_state",  state,     7);
        en = 1'b0;
        step();
        check_eq("flt_off_state", state,     0);
        check_eq("flt_off_fault", fault,     0);
        check_eq("flt_off_retry", retry_cnt, 3);

        // Fast bring-up with all inputs already high (UP at 28), then rst_glbl.
        pma_tx_rdy = 1'b1; pma_rx_rdy = 1'b1; block_lock = 1'b1;
        repeat (3) step();
        en = 1'b1;
        repeat (28) step();
        check_eq("re_up_state", state,   6);
        check_eq("re_up_link",  link_up, 1);
        rst_glbl = 1'b1;
        step();
        check_eq("sr_state",   state,     0);
        check_eq("sr_trx_rst", trx_rst,   1);
        check_eq("sr_link_up", link_up,   0);
        check_eq("sr_fault",   fault,     0);
        check_eq("sr_retry",   retry_cnt, 0);
`ifdef TRX_LINK_SUP_STATS_EN
        check_eq("sr_drop",    drop_cnt,  0);
`endif
        rst_glbl = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
